// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback request sources plus register_bank write port
//   s0_*/s1_*  valid/ready request channels: addr, lane mask, lane data
//   write_en, waddr, wdata  registered write to register_bank
//   wb_pending  per-register outstanding-write scoreboard
//   idle        nothing queued and output stage empty
interface rf_wb_arbiter_if #(
    parameter int LANES = 8,
    parameter int DW    = 32,
    parameter int AW    = 4
);
    logic                  s0_valid;
    logic                  s0_ready;
    logic [AW-1:0]         s0_addr;
    logic [LANES-1:0]      s0_mask;
    logic [LANES*DW-1:0]   s0_data;
    logic                  s1_valid;
    logic                  s1_ready;
    logic [AW-1:0]         s1_addr;
    logic [LANES-1:0]      s1_mask;
    logic [LANES*DW-1:0]   s1_data;
    logic [LANES-1:0]      write_en;
    logic [AW-1:0]         waddr;
    logic [LANES*DW-1:0]   wdata;
    logic [2**AW-1:0]      wb_pending;
    logic                  idle;
    modport master (
        output s0_valid, s0_addr, s0_mask, s0_data,
        output s1_valid, s1_addr, s1_mask, s1_data,
        input  s0_ready, s1_ready, write_en, waddr, wdata, wb_pending, idle
    );
    modport slave (
        input  s0_valid, s0_addr, s0_mask, s0_data,
        input  s1_valid, s1_addr, s1_mask, s1_data,
        output s0_ready, s1_ready, write_en, waddr, wdata, wb_pending, idle
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of the register_bank write port between ALU (src 0) and LSU (src 1)
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    rf_wb_arbiter_if.slave: two valid/ready sources in, bank write port,
//          wb_pending scoreboard and idle out
module rf_wb_arbiter #(
    parameter int LANES = 8,
    parameter int DW    = 32,
    parameter int AW    = 4,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    rf_wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = AW + LANES + LANES * DW;
    logic [EW-1:0]        in_ent [2];
    logic [EW-1:0]        mem    [2][DEPTH];
    logic [EW-1:0]        head   [2];
    logic [DEPTH-1:0]     vld    [2];
    logic [PW-1:0]        wp     [2];
    logic [PW-1:0]        rp     [2];
    logic [EW-1:0]        gnt_ent;
    logic [1:0]           in_valid, ready, ne, push, pop;
    logic                 rr, ov;
    logic [LANES-1:0]     we_q;
    logic [AW-1:0]        addr_q;
    logic [LANES*DW-1:0]  data_q;
    logic [2**AW-1:0]     pend;
    assign in_valid  = {bus.s1_valid, bus.s0_valid};
    assign in_ent[0] = {bus.s0_addr, bus.s0_mask, bus.s0_data};
    assign in_ent[1] = {bus.s1_addr, bus.s1_mask, bus.s1_data};
    // per-slot valid bits make full/empty pure functions of registered state
    for (genvar s = 0; s < 2; s++) begin : g_src
        assign ready[s] = ~&vld[s];
        assign ne[s]    = vld[s][rp[s]];
        assign head[s]  = mem[s][rp[s]];
    end
    assign push = in_valid & ready;
    // rr=0 favours src 0 when both heads are present
    assign pop[0]  = ne[0] & (~ne[1] | ~rr);
    assign pop[1]  = ne[1] & ~pop[0];
    assign gnt_ent = pop[1] ? head[1] : head[0];
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++)
            if (push[s]) mem[s][wp[s]] <= in_ent[s];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                vld[s] <= '0;
                wp[s]  <= '0;
                rp[s]  <= '0;
            end
        end else begin
            // push and pop never hit the same slot: pop needs non-empty, push needs non-full
            for (int s = 0; s < 2; s++) begin
                if (pop[s]) begin
                    vld[s][rp[s]] <= 1'b0;
                    rp[s]         <= rp[s] + 1'b1;
                end
                if (push[s]) begin
                    vld[s][wp[s]] <= 1'b1;
                    wp[s]         <= wp[s] + 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr     <= 1'b0;
            ov     <= 1'b0;
            we_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            rr   <= (&ne) ? ~rr : rr;
            ov   <= |pop;
            we_q <= (|pop) ? gnt_ent[EW-AW-1 -: LANES] : '0;
            if (|pop) begin
                addr_q <= gnt_ent[EW-1 -: AW];
                data_q <= gnt_ent[LANES*DW-1:0];
            end
        end
    end
    // mask is ignored: a zero-mask entry still blocks readers until it retires
    always_comb begin
        pend = '0;
        if (ov) pend[addr_q] = 1'b1;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++)
                if (vld[s][i]) pend[mem[s][i][EW-1 -: AW]] = 1'b1;
    end
    assign bus.s0_ready   = ready[0];
    assign bus.s1_ready   = ready[1];
    assign bus.write_en   = we_q;
    assign bus.waddr      = addr_q;
    assign bus.wdata      = data_q;
    assign bus.wb_pending = pend;
    assign bus.idle       = ~|vld[0] & ~|vld[1] & ~ov;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: randomized and directed checks of rf_wb_arbiter against a queue-based model
module tb_rf_wb_arbiter;
    localparam int LANES = 8, DW = 32, AW = 4, DEPTH = 2, NR = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    rf_wb_arbiter_if #(.LANES(LANES), .DW(DW), .AW(AW)) bus();
    rf_wb_arbiter #(.LANES(LANES), .DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [AW-1:0]        addr;
        logic [LANES-1:0]     mask;
        logic [LANES*DW-1:0]  data;
    } ent_t;
    int checks = 0;
    int passed = 0;
    ent_t mq0[$];
    ent_t mq1[$];
    logic                 m_rr, m_ov;
    logic [LANES-1:0]     m_we;
    logic [AW-1:0]        m_addr;
    logic [LANES*DW-1:0]  m_data;
    logic [LANES*DW-1:0]  m_bank [NR];
    logic [LANES*DW-1:0]  bank   [NR];
    int r3_writes = 0;
    // register_bank stand-in written by the DUT's output stage
    always @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < LANES; k++)
                if (bus.write_en[k]) bank[bus.waddr][k*DW +: DW] <= bus.wdata[k*DW +: DW];
            if (bus.write_en != 0 && bus.waddr == 4'd3) r3_writes <= r3_writes + 1;
        end
    end
    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        m_rr = 0; m_ov = 0; m_we = '0; m_addr = '0; m_data = '0;
    endtask
    // advance the model across one clock edge using the inputs currently driven
    task automatic model_step();
        ent_t e;
        int g;
        bit a0, a1;
        if (m_ov)
            for (int k = 0; k < LANES; k++)
                if (m_we[k]) m_bank[m_addr][k*DW +: DW] = m_data[k*DW +: DW];
        a0 = bus.s0_valid && mq0.size() < DEPTH;
        a1 = bus.s1_valid && mq1.size() < DEPTH;
        g = -1;
        if (mq0.size() > 0 && mq1.size() > 0) begin
            g = m_rr ? 1 : 0;
            m_rr = !m_rr;
        end else if (mq0.size() > 0) g = 0;
        else if (mq1.size() > 0) g = 1;
        if (g == 0) e = mq0.pop_front();
        if (g == 1) e = mq1.pop_front();
        if (g >= 0) begin
            m_ov = 1; m_we = e.mask; m_addr = e.addr; m_data = e.data;
        end else begin
            m_ov = 0; m_we = '0;
        end
        if (a0) mq0.push_back('{bus.s0_addr, bus.s0_mask, bus.s0_data});
        if (a1) mq1.push_back('{bus.s1_addr, bus.s1_mask, bus.s1_data});
    endtask
    function automatic logic [NR-1:0] m_pend();
        logic [NR-1:0] r = '0;
        if (m_ov) r[m_addr] = 1'b1;
        foreach (mq0[i]) r[mq0[i].addr] = 1'b1;
        foreach (mq1[i]) r[mq1[i].addr] = 1'b1;
        return r;
    endfunction
    function automatic logic [LANES*DW-1:0] rnd_data();
        logic [LANES*DW-1:0] d;
        for (int k = 0; k < LANES; k++) d[k*DW +: DW] = $urandom;
        return d;
    endfunction
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input int s, input logic v, input logic [AW-1:0] a,
                         input logic [LANES-1:0] m, input logic [LANES*DW-1:0] d);
        if (s == 0) begin
            bus.s0_valid = v; bus.s0_addr = a; bus.s0_mask = m; bus.s0_data = d;
        end else begin
            bus.s1_valid = v; bus.s1_addr = a; bus.s1_mask = m; bus.s1_data = d;
        end
    endtask
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.write_en !== '0) $display("FAIL reset write_en: got %h want 0", bus.write_en); else passed++;
        checks++; if (bus.waddr !== '0) $display("FAIL reset waddr: got %h want 0", bus.waddr); else passed++;
        checks++; if (bus.wdata !== '0) $display("FAIL reset wdata: got %h want 0", bus.wdata); else passed++;
        checks++; if (bus.wb_pending !== '0) $display("FAIL reset wb_pending: got %h want 0", bus.wb_pending); else passed++;
        checks++; if (bus.idle !== 1'b1) $display("FAIL reset idle: got %b want 1", bus.idle); else passed++;
        checks++; if ({bus.s0_ready, bus.s1_ready} !== 2'b11) $display("FAIL reset ready: got %b want 11", {bus.s0_ready, bus.s1_ready}); else passed++;
        rst_n = 1'b1;
        model_reset();
        step();
        checks++; if (bus.idle !== 1'b1) $display("FAIL post-reset idle: got %b want 1", bus.idle); else passed++;
    endtask
    task automatic test_back_to_back();
        int cyc[$];
        logic [AW-1:0] log_a[$];
        for (int i = 0; i < NR + 4; i++) begin
            drive(0, i < NR, 4'(i), 8'hFF, '0);
            checks++; if (bus.s0_ready !== (mq0.size() < DEPTH)) $display("FAIL b2b s0_ready: got %b want %b", bus.s0_ready, mq0.size() < DEPTH); else passed++;
            step();
            if (bus.write_en != 0) begin cyc.push_back(i); log_a.push_back(bus.waddr); end
        end
        checks++; if (log_a.size() !== NR) $display("FAIL b2b count: got %0d want %0d", log_a.size(), NR); else passed++;
        if (log_a.size() == NR) begin
            checks++; if (cyc[NR-1] - cyc[0] !== NR - 1) $display("FAIL b2b throughput span: got %0d want %0d", cyc[NR-1] - cyc[0], NR - 1); else passed++;
            for (int i = 0; i < NR; i++) begin
                checks++; if (log_a[i] !== 4'(i)) $display("FAIL b2b order[%0d]: got %0d want %0d", i, log_a[i], i); else passed++;
            end
        end
    endtask
    task automatic test_single();
        logic [LANES*DW-1:0] d;
        for (int k = 0; k < LANES; k++) d[k*DW +: DW] = 32'hA5A5_0000 | k;
        drive(0, 1, 4'd5, 8'hFF, d);
        step();
        drive(0, 0, '0, '0, '0);
        checks++; if (bus.wb_pending[5] !== 1'b1) $display("FAIL single pending N+1: got %b want 1", bus.wb_pending[5]); else passed++;
        checks++; if (bus.write_en !== '0) $display("FAIL single write_en N+1: got %h want 0", bus.write_en); else passed++;
        step();
        checks++; if (bus.write_en !== 8'hFF) $display("FAIL single write_en N+2: got %h want ff", bus.write_en); else passed++;
        checks++; if (bus.waddr !== 4'd5) $display("FAIL single waddr: got %0d want 5", bus.waddr); else passed++;
        checks++; if (bus.wdata !== d) $display("FAIL single wdata: got %h want %h", bus.wdata, d); else passed++;
        checks++; if (bus.wb_pending[5] !== 1'b1) $display("FAIL single pending N+2: got %b want 1", bus.wb_pending[5]); else passed++;
        step();
        for (int k = 0; k < LANES; k++) begin
            checks++; if (bank[5][k*DW +: DW] !== (32'hA5A5_0000 | k)) $display("FAIL single bank lane %0d: got %h want %h", k, bank[5][k*DW +: DW], 32'hA5A5_0000 | k); else passed++;
        end
        checks++; if (bus.wb_pending[5] !== 1'b0) $display("FAIL single pending cleared: got %b want 0", bus.wb_pending[5]); else passed++;
        checks++; if (bus.idle !== 1'b1) $display("FAIL single idle: got %b want 1", bus.idle); else passed++;
    endtask
    task automatic test_round_robin();
        int i0 = 0, i1 = 0;
        bit r0, r1;
        logic [AW-1:0] log_a[$];
        logic [AW-1:0] exp_a[8] = '{0, 8, 1, 9, 2, 10, 3, 11};
        for (int c = 0; c < 30; c++) begin
            drive(0, i0 < 4, 4'(i0), 8'hFF, {LANES{32'(i0)}});
            drive(1, i1 < 4, 4'(8 + i1), 8'hFF, {LANES{32'(8 + i1)}});
            r0 = mq0.size() < DEPTH;
            r1 = mq1.size() < DEPTH;
            step();
            if (i0 < 4 && r0) i0++;
            if (i1 < 4 && r1) i1++;
            checks++; if (bus.write_en !== m_we) $display("FAIL rr write_en c%0d: got %h want %h", c, bus.write_en, m_we); else passed++;
            if (bus.write_en != 0) log_a.push_back(bus.waddr);
        end
        checks++; if (log_a.size() !== 8) $display("FAIL rr count: got %0d want 8", log_a.size()); else passed++;
        for (int i = 0; i < 8 && i < log_a.size(); i++) begin
            checks++; if (log_a[i] !== exp_a[i]) $display("FAIL rr waddr[%0d]: got %0d want %0d", i, log_a[i], exp_a[i]); else passed++;
        end
    endtask
    task automatic test_backpressure();
        int i0 = 0, i1 = 0;
        bit saw_block = 0;
        logic [AW-1:0] acc1[$];
        logic [AW-1:0] log1[$];
        for (int c = 0; c < 16; c++) begin
            drive(0, c < 4, 4'(i0), 8'hFF, rnd_data());
            drive(1, c < 4, 4'(12 + i1), 8'hFF, rnd_data());
            checks++; if (bus.s1_ready !== (mq1.size() < DEPTH)) $display("FAIL bp s1_ready c%0d: got %b want %b", c, bus.s1_ready, mq1.size() < DEPTH); else passed++;
            if (c < 4 && !bus.s1_ready) saw_block = 1;
            if (c < 4 && mq0.size() < DEPTH) i0++;
            if (c < 4 && mq1.size() < DEPTH) begin acc1.push_back(4'(12 + i1)); i1++; end
            step();
            if (bus.write_en != 0 && bus.waddr >= 4'd12) log1.push_back(bus.waddr);
        end
        checks++; if (saw_block !== 1'b1) $display("FAIL bp s1_ready never dropped: got %b want 1", saw_block); else passed++;
        checks++; if (log1.size() !== acc1.size()) $display("FAIL bp s1 write count: got %0d want %0d", log1.size(), acc1.size()); else passed++;
        for (int i = 0; i < acc1.size() && i < log1.size(); i++) begin
            checks++; if (log1[i] !== acc1[i]) $display("FAIL bp s1 order[%0d]: got %0d want %0d", i, log1[i], acc1[i]); else passed++;
        end
    endtask
    task automatic test_lane_mask();
        drive(0, 1, 4'd7, 8'hFF, '0);
        step();
        drive(0, 1, 4'd7, 8'h05, {LANES{32'hDEAD_BEEF}});
        step();
        drive(0, 0, '0, '0, '0);
        repeat (4) step();
        for (int k = 0; k < LANES; k++) begin
            checks++;
            if (bank[7][k*DW +: DW] !== ((k == 0 || k == 2) ? 32'hDEAD_BEEF : 32'h0))
                $display("FAIL lane mask lane %0d: got %h want %h", k, bank[7][k*DW +: DW], (k == 0 || k == 2) ? 32'hDEAD_BEEF : 32'h0);
            else passed++;
        end
    endtask
    task automatic test_zero_mask();
        drive(1, 1, 4'd2, 8'h00, rnd_data());
        step();
        drive(1, 0, '0, '0, '0);
        checks++; if (bus.wb_pending[2] !== 1'b1) $display("FAIL zero pending N+1: got %b want 1", bus.wb_pending[2]); else passed++;
        checks++; if (bus.idle !== 1'b0) $display("FAIL zero idle N+1: got %b want 0", bus.idle); else passed++;
        step();
        checks++; if (bus.write_en !== '0) $display("FAIL zero write_en: got %h want 0", bus.write_en); else passed++;
        checks++; if (bus.wb_pending[2] !== 1'b1) $display("FAIL zero pending N+2: got %b want 1", bus.wb_pending[2]); else passed++;
        checks++; if (bus.idle !== 1'b0) $display("FAIL zero idle slot: got %b want 0", bus.idle); else passed++;
        step();
        checks++; if (bus.wb_pending[2] !== 1'b0) $display("FAIL zero pending cleared: got %b want 0", bus.wb_pending[2]); else passed++;
        checks++; if (bus.idle !== 1'b1) $display("FAIL zero idle return: got %b want 1", bus.idle); else passed++;
        checks++; if (bank[2] !== m_bank[2]) $display("FAIL zero r2 changed: got %h want %h", bank[2], m_bank[2]); else passed++;
    endtask
    task automatic test_random();
        for (int c = 0; c < 420; c++) begin
            for (int s = 0; s < 2; s++)
                drive(s, c < 400 && $urandom_range(0, 3) != 0, 4'($urandom_range(0, NR - 1)),
                      $urandom_range(0, 7) == 0 ? 8'h00 : 8'($urandom), rnd_data());
            checks++; if ({bus.s1_ready, bus.s0_ready} !== {mq1.size() < DEPTH, mq0.size() < DEPTH})
                $display("FAIL rand ready c%0d: got %b want %b", c, {bus.s1_ready, bus.s0_ready}, {mq1.size() < DEPTH, mq0.size() < DEPTH}); else passed++;
            step();
            checks++; if (bus.write_en !== m_we) $display("FAIL rand write_en c%0d: got %h want %h", c, bus.write_en, m_we); else passed++;
            checks++; if (bus.waddr !== m_addr) $display("FAIL rand waddr c%0d: got %h want %h", c, bus.waddr, m_addr); else passed++;
            checks++; if (bus.wdata !== m_data) $display("FAIL rand wdata c%0d: got %h want %h", c, bus.wdata, m_data); else passed++;
            checks++; if (bus.wb_pending !== m_pend()) $display("FAIL rand wb_pending c%0d: got %h want %h", c, bus.wb_pending, m_pend()); else passed++;
            checks++; if (bus.idle !== (mq0.size() == 0 && mq1.size() == 0 && !m_ov)) $display("FAIL rand idle c%0d: got %b want %b", c, bus.idle, mq0.size() == 0 && mq1.size() == 0 && !m_ov); else passed++;
        end
        for (int r = 0; r < NR; r++) begin
            checks++; if (bank[r] !== m_bank[r]) $display("FAIL rand bank r%0d: got %h want %h", r, bank[r], m_bank[r]); else passed++;
        end
    endtask
    task automatic test_reset_mid();
        int snap;
        drive(0, 1, 4'd3, 8'hFF, {LANES{32'h1234_5678}});
        step();
        step();
        drive(0, 0, '0, '0, '0);
        checks++; if (bus.write_en !== 8'hFF) $display("FAIL midrst staged write_en: got %h want ff", bus.write_en); else passed++;
        rst_n = 1'b0;
        #2;
        checks++; if (bus.write_en !== '0) $display("FAIL midrst write_en: got %h want 0", bus.write_en); else passed++;
        checks++; if (bus.wb_pending !== '0) $display("FAIL midrst wb_pending: got %h want 0", bus.wb_pending); else passed++;
        checks++; if (bus.s0_ready !== 1'b1) $display("FAIL midrst s0_ready: got %b want 1", bus.s0_ready); else passed++;
        checks++; if (bus.idle !== 1'b1) $display("FAIL midrst idle: got %b want 1", bus.idle); else passed++;
        model_reset();
        snap = r3_writes;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) step();
        checks++; if (r3_writes !== snap) $display("FAIL midrst r3 writes: got %0d want %0d", r3_writes, snap); else passed++;
        checks++; if (bank[3] !== m_bank[3]) $display("FAIL midrst r3 value: got %h want %h", bank[3], m_bank[3]); else passed++;
        checks++; if (bus.idle !== 1'b1) $display("FAIL midrst idle after: got %b want 1", bus.idle); else passed++;
    endtask
    initial begin
        drive(0, 0, '0, '0, '0);
        drive(1, 0, '0, '0, '0);
        test_reset();
        test_back_to_back();
        test_single();
        test_round_robin();
        test_backpressure();
        test_lane_mask();
        test_zero_mask();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
